pudding_thermo_dac_ctrl: RTL and testbench
==========================================

Name: pudding_thermo_dac_ctrl

Overview:
Parametrised thermometer-DAC code generator; next generation of the fixed 4-bit triangle/shift-register driver. Generates the DAC code internally (hold, sawtooth or triangle, with programmable step and rate prescaler) or takes a byte-serially loaded, double-buffered direct thermometer word. Registered thermometer output feeds the downstream non-overlap / switch-driver stage.

Parameters:
BITS, 4, binary code width; THERMO_W = 2**BITS-1 (localparam), thermo bit i set iff i < code
PRESC_W, 8, prescaler width; pattern advances once every presc+1 enabled cycles
LOAD_BYTES, ceil(THERMO_W/8) (localparam), bytes per full direct word

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  enable; low freezes prescaler, pattern and outputs
mode  in  2  0 HOLD, 1 SAWTOOTH, 2 TRIANGLE, 3 DIRECT
step  in  BITS  code increment per tick (SAWTOOTH/TRIANGLE)
presc  in  PRESC_W  tick divider
hold_code  in  BITS  code used in HOLD
load_valid  in  1  shift load_data into staging register this cycle
load_data  in  8  serial byte, MSB-first word assembly
load_commit  in  1  copy staging register to shadow register
code_o  out  BITS  current binary code
thermo_o  out  THERMO_W  registered thermometer word
dir_o  out  1  triangle direction, 1 = up
tick_o  out  1  one-cycle pulse on each pattern update

Behaviour:
- Reset (async, rst_n=0): code_o=0, thermo_o=0, dir_o=1, tick_o=0, prescaler=0, staging=0, shadow=0, mode_q=0.
- Prescaler: while en=1, counts 0..presc; tick when count==presc, count returns to 0. presc=0 -> tick every enabled cycle. en=0: counter, code, dir held; tick_o=0.
- mode_q registers mode; any change (mode != mode_q) clears prescaler, sets dir_o=1, no tick that cycle; code_o retained.
- On tick, code_o and thermo_o update on the same edge (1-cycle latency from tick condition); tick_o high that same cycle.
- HOLD: code <= hold_code.
- SAWTOOTH: code <= (code+step) mod 2**BITS (natural wrap). step=0 -> code constant, tick still pulses.
- TRIANGLE, up: if code+step >= 2**BITS-1 (evaluate at BITS+1 width) then code <= 2**BITS-1, dir <= 0; else code <= code+step. Down: if code <= step then code <= 0, dir <= 1; else code <= code-step. Endpoints hit exactly, never overshoot.
- Non-DIRECT: thermo_o <= thermometer(next code).
- DIRECT: thermo_o <= shadow; code_o <= popcount(shadow) (saturating into BITS).
- Staging: load_valid -> staging <= {staging, load_data} truncated to LOAD_BYTES*8 bits; low THERMO_W bits are the word. Usable in any mode, independent of en.
- load_commit -> shadow <= staging[THERMO_W-1:0]. Same-cycle load_valid+load_commit: shadow takes pre-shift staging; byte still shifted in.
- Shadow reaches thermo_o only on a DIRECT tick (glitch-free double buffering).
- Reset mid-load discards staging and shadow.

Optional Feature:
Macro THERMO_BUBBLE_FIX_EN. With it: in DIRECT, shadow is checked on each tick; a non-thermometer word (any 1 above a 0) is replaced by thermometer(popcount(shadow)) before driving thermo_o, and extra output err_o (1 bit, reset 0) pulses high for that tick. Without it: shadow passed through unchanged; no err_o port.

Test Plan:
BITS=4, presc=0, TRIANGLE, step=1, en=1 from reset -> code 1..15, dir_o falls with code=15, down to 0, dir_o rises; thermo_o=0x7FFF at peak.
TRIANGLE step=4 -> code 0,4,8,12,15,11,7,3,0,4 (endpoints clamped).
SAWTOOTH step=3, presc=2 -> tick_o every 3rd cycle; code 0,3,...,15,2 (wrap).
DIRECT: load_valid bytes 0x3F then 0xFF, load_commit, one tick -> thermo_o=0x3FFF, code_o=14; commit without tick leaves thermo_o unchanged.
en=0 for 5 cycles mid-triangle -> code_o, dir_o, prescaler frozen, tick_o=0; resumes next value on en=1; rst_n low mid-run -> all outputs 0, dir_o=1 asynchronously.
THERMO_BUBBLE_FIX_EN: DIRECT word 0x00F5 -> thermo_o=0x003F, err_o one-cycle pulse; word 0x00FF -> err_o stays 0.

Source files
------------

// File: rtl/pudding_thermo_dac_ctrl.sv
// pudding_thermo_dac_ctrl: thermometer-DAC code generator.
// Generates a binary code (HOLD, SAWTOOTH, TRIANGLE) on prescaled ticks, or
// drives a byte-serially loaded, double-buffered direct thermometer word
// (DIRECT). The thermometer output is registered for the switch-driver stage.
// Optional feature macro: THERMO_BUBBLE_FIX_EN (adds err_o; DIRECT words
// that are not valid thermometer codes are repaired from their popcount).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                enable; low freezes prescaler, pattern and outputs
//   mode              0 HOLD, 1 SAWTOOTH, 2 TRIANGLE, 3 DIRECT
//   step, presc       code increment per tick, tick divider (presc+1 cycles)
//   hold_code         code used in HOLD
//   load_valid/data   shift one byte into the staging register (MSB-first)
//   load_commit       copy staging word into the shadow register
//   code_o, thermo_o  current binary code and its registered thermometer word
//   dir_o, tick_o     triangle direction (1 = up), pattern-update pulse
//   err_o             (macro only) bubble repaired on this DIRECT tick
module pudding_thermo_dac_ctrl #(
  parameter int unsigned BITS    = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [BITS-1:0]          step,
  input  logic [PRESC_W-1:0]       presc,
  input  logic [BITS-1:0]          hold_code,
  input  logic                     load_valid,
  input  logic [7:0]               load_data,
  input  logic                     load_commit,
  output logic [BITS-1:0]          code_o,
  output logic [(2**BITS)-2:0]     thermo_o,
  output logic                     dir_o,
  output logic                     tick_o
`ifdef THERMO_BUBBLE_FIX_EN
  ,
  output logic                     err_o
`endif
);

  localparam int unsigned THERMO_W   = (1 << BITS) - 1;
  localparam int unsigned LOAD_BYTES = (THERMO_W + 7) / 8;
  localparam int unsigned LOAD_W     = LOAD_BYTES * 8;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_DIR  = 2'd3;

  localparam logic [BITS-1:0] CODE_MAX = '1;

  logic [PRESC_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]     code_q, code_d;
  logic [THERMO_W-1:0] thermo_q, thermo_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d;
  logic [1:0]          mode_q;
  logic [LOAD_W-1:0]   staging_q, staging_d;
  logic [THERMO_W-1:0] shadow_q, shadow_d;
  logic [BITS:0]       tri_sum;
  logic [BITS-1:0]     shadow_pc;
  logic [THERMO_W-1:0] shadow_fixed;

  // Thermometer encode: bit i set iff i < c.
  function automatic logic [THERMO_W-1:0] thermo_of(input logic [BITS-1:0] c);
    logic [THERMO_W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(THERMO_W); i++) t[i] = (32'(i) < 32'(c));
    return t;
  endfunction

  // Population count saturated into the code width.
  function automatic logic [BITS-1:0] popcount_sat(input logic [THERMO_W-1:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(THERMO_W); i++) n = n + 32'(w[i]);
    return (n > THERMO_W) ? CODE_MAX : BITS'(n);
  endfunction

  // Triangle up-step evaluated one bit wider so the peak clamp sees overflow.
  assign tri_sum      = {1'b0, code_q} + {1'b0, step};
  assign shadow_pc    = popcount_sat(shadow_q);
  assign shadow_fixed = thermo_of(shadow_pc);

`ifdef THERMO_BUBBLE_FIX_EN
  logic err_q, err_d;
`endif

  // Next-state logic: staging/shadow loading, prescaler, pattern update.
  always_comb begin
    cnt_d     = cnt_q;
    code_d    = code_q;
    thermo_d  = thermo_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    staging_d = staging_q;
    shadow_d  = shadow_q;
`ifdef THERMO_BUBBLE_FIX_EN
    err_d     = 1'b0;
`endif

    // Commit samples the pre-shift staging word when both strobes coincide.
    if (load_valid)  staging_d = LOAD_W'({staging_q, load_data});
    if (load_commit) shadow_d  = staging_q[THERMO_W-1:0];

    if (mode != mode_q) begin
      cnt_d = '0;
      dir_d = 1'b1;
    end else if (en) begin
      if (cnt_q >= presc) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        unique case (mode_q)
          MODE_HOLD: code_d = hold_code;
          MODE_SAW:  code_d = code_q + step;
          MODE_TRI: begin
            if (dir_q) begin
              if (tri_sum >= {1'b0, CODE_MAX}) begin
                code_d = CODE_MAX;
                dir_d  = 1'b0;
              end else begin
                code_d = tri_sum[BITS-1:0];
              end
            end else begin
              if (code_q <= step) begin
                code_d = '0;
                dir_d  = 1'b1;
              end else begin
                code_d = code_q - step;
              end
            end
          end
          default: code_d = shadow_pc;
        endcase
        if (mode_q == MODE_DIR) begin
`ifdef THERMO_BUBBLE_FIX_EN
          // A valid thermometer word equals the encode of its own popcount.
          thermo_d = shadow_fixed;
          err_d    = (shadow_q != shadow_fixed);
`else
          thermo_d = shadow_q;
`endif
        end else begin
          thermo_d = thermo_of(code_d);
        end
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      code_q    <= '0;
      thermo_q  <= '0;
      dir_q     <= 1'b1;
      tick_q    <= 1'b0;
      mode_q    <= MODE_HOLD;
      staging_q <= '0;
      shadow_q  <= '0;
`ifdef THERMO_BUBBLE_FIX_EN
      err_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      thermo_q  <= thermo_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      mode_q    <= mode;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
`ifdef THERMO_BUBBLE_FIX_EN
      err_q     <= err_d;
`endif
    end
  end

  assign code_o   = code_q;
  assign thermo_o = thermo_q;
  assign dir_o    = dir_q;
  assign tick_o   = tick_q;
`ifdef THERMO_BUBBLE_FIX_EN
  assign err_o    = err_q;
`endif

endmodule

// File: tb/tb_pudding_thermo_dac_ctrl.sv
// Directed self-checking bench for pudding_thermo_dac_ctrl (BITS=4, PRESC_W=8).
module tb_pudding_thermo_dac_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  step;
  logic [7:0]  presc;
  logic [3:0]  hold_code;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_commit;
  logic [3:0]  code_o;
  logic [14:0] thermo_o;
  logic        dir_o;
  logic        tick_o;
`ifdef THERMO_BUBBLE_FIX_EN
  logic        err_o;
`endif

  int total = 0;
  int bad   = 0;

  pudding_thermo_dac_ctrl #(.BITS(4), .PRESC_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .step        (step),
    .presc       (presc),
    .hold_code   (hold_code),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_commit (load_commit),
    .code_o      (code_o),
    .thermo_o    (thermo_o),
    .dir_o       (dir_o),
    .tick_o      (tick_o)
`ifdef THERMO_BUBBLE_FIX_EN
    ,
    .err_o       (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  tri4_code [9];
    logic        tri4_dir  [9];
    logic [3:0]  saw_code  [6];
    logic [14:0] exp_t;

    tri4_code = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd11, 4'd7, 4'd3, 4'd0, 4'd4};
    tri4_dir  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    saw_code  = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; step = '0; presc = '0; hold_code = '0;
    load_valid = 1'b0; load_data = '0; load_commit = 1'b0;
    repeat (3) cyc();
    check("rst_code",   32'(code_o),   32'd0);
    check("rst_thermo", 32'(thermo_o), 32'd0);
    check("rst_dir",    32'(dir_o),    32'd1);
    check("rst_tick",   32'(tick_o),   32'd0);

    // Triangle, step 1: the mode-change cycle produces no tick.
    rst_n = 1'b1; mode = 2'd2; step = 4'd1; en = 1'b1;
    cyc();
    check("tri1_mchg_tick", 32'(tick_o), 32'd0);
    check("tri1_mchg_code", 32'(code_o), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      cyc();
      exp_t = 15'((32'd1 << k) - 32'd1);
      check("tri1_up_code",   32'(code_o),   32'(k));
      check("tri1_up_tick",   32'(tick_o),   32'd1);
      check("tri1_up_dir",    32'(dir_o),    (k == 15) ? 32'd0 : 32'd1);
      check("tri1_up_thermo", 32'(thermo_o), 32'(exp_t));
    end
    for (int k = 14; k >= 0; k--) begin
      cyc();
      exp_t = 15'((32'd1 << k) - 32'd1);
      check("tri1_dn_code",   32'(code_o),   32'(k));
      check("tri1_dn_dir",    32'(dir_o),    (k == 0) ? 32'd1 : 32'd0);
      check("tri1_dn_thermo", 32'(thermo_o), 32'(exp_t));
    end

    // Triangle, step 4: endpoints clamp exactly.
    step = 4'd4;
    for (int k = 0; k < 9; k++) begin
      cyc();
      check("tri4_code", 32'(code_o), 32'(tri4_code[k]));
      check("tri4_dir",  32'(dir_o),  32'(tri4_dir[k]));
    end

    // Freeze with en low.
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("frz_code", 32'(code_o), 32'd4);
      check("frz_dir",  32'(dir_o),  32'd1);
      check("frz_tick", 32'(tick_o), 32'd0);
    end
    en = 1'b1;
    cyc();
    check("resume_code", 32'(code_o), 32'd8);
    check("resume_tick", 32'(tick_o), 32'd1);

    // HOLD to zero, then sawtooth step 3 with presc 2.
    mode = 2'd0; hold_code = 4'd0;
    cyc();
    check("hold_mchg_code", 32'(code_o), 32'd8);
    check("hold_mchg_tick", 32'(tick_o), 32'd0);
    cyc();
    check("hold_code", 32'(code_o), 32'd0);
    mode = 2'd1; step = 4'd3; presc = 8'd2;
    cyc();
    check("saw_mchg_tick", 32'(tick_o), 32'd0);
    for (int j = 0; j < 6; j++) begin
      cyc();
      check("saw_gap1_tick", 32'(tick_o), 32'd0);
      cyc();
      check("saw_gap2_tick", 32'(tick_o), 32'd0);
      cyc();
      check("saw_tick", 32'(tick_o), 32'd1);
      check("saw_code", 32'(code_o), 32'(saw_code[j]));
    end
    check("saw_wrap_thermo", 32'(thermo_o), 32'h0003);

    // Load and commit while frozen: output must not change.
    en = 1'b0; load_valid = 1'b1; load_data = 8'h3F;
    cyc();
    load_data = 8'hFF;
    cyc();
    load_valid = 1'b0; load_commit = 1'b1;
    cyc();
    load_commit = 1'b0;
    cyc();
    check("commit_no_tick_thermo", 32'(thermo_o), 32'h0003);
    check("commit_no_tick_code",   32'(code_o),   32'd2);

    mode = 2'd3; presc = 8'd0; en = 1'b1;
    cyc();
    check("dir_mchg_thermo", 32'(thermo_o), 32'h0003);
    check("dir_mchg_tick",   32'(tick_o),   32'd0);
    cyc();
    check("dir_thermo", 32'(thermo_o), 32'h3FFF);
    check("dir_code",   32'(code_o),   32'd14);
    check("dir_tick",   32'(tick_o),   32'd1);

    // Staged but uncommitted data stays off the output.
    load_valid = 1'b1; load_data = 8'h00;
    cyc();
    load_data = 8'h01;
    cyc();
    load_valid = 1'b0;
    cyc();
    check("staged_only_thermo", 32'(thermo_o), 32'h3FFF);
    load_commit = 1'b1;
    cyc();
    load_commit = 1'b0;
    check("commit_edge_thermo", 32'(thermo_o), 32'h3FFF);
    cyc();
    check("commit_next_thermo", 32'(thermo_o), 32'h0001);
    check("commit_next_code",   32'(code_o),   32'd1);

    // Same-cycle shift + commit: shadow gets the pre-shift word.
    load_valid = 1'b1; load_data = 8'h07; load_commit = 1'b1;
    cyc();
    load_valid = 1'b0; load_commit = 1'b0;
    cyc();
    check("same_cyc_thermo", 32'(thermo_o), 32'h0001);
    load_commit = 1'b1;
    cyc();
    load_commit = 1'b0;
    cyc();
    check("bubble_word_code", 32'(code_o), 32'd4);
`ifdef THERMO_BUBBLE_FIX_EN
    check("bubble_word_thermo", 32'(thermo_o), 32'h000F);
    check("bubble_word_err",    32'(err_o),    32'd1);

    // 0x00F5 repaired to popcount 6; err_o pulses for the single tick.
    load_valid = 1'b1; load_data = 8'h00;
    cyc();
    load_data = 8'hF5;
    cyc();
    load_valid = 1'b0; load_commit = 1'b1;
    cyc();
    load_commit = 1'b0;
    cyc();
    check("fix_f5_thermo", 32'(thermo_o), 32'h003F);
    check("fix_f5_code",   32'(code_o),   32'd6);
    check("fix_f5_err",    32'(err_o),    32'd1);
    en = 1'b0;
    cyc();
    check("fix_f5_err_pulse", 32'(err_o),    32'd0);
    check("fix_f5_hold",      32'(thermo_o), 32'h003F);
    load_valid = 1'b1; load_data = 8'h00;
    cyc();
    load_data = 8'hFF;
    cyc();
    load_valid = 1'b0; load_commit = 1'b1;
    cyc();
    load_commit = 1'b0; en = 1'b1;
    cyc();
    check("fix_ff_thermo", 32'(thermo_o), 32'h00FF);
    check("fix_ff_code",   32'(code_o),   32'd8);
    check("fix_ff_err",    32'(err_o),    32'd0);
`else
    check("bubble_word_thermo", 32'(thermo_o), 32'h0107);
`endif

    // Asynchronous reset mid-cycle.
    #1 rst_n = 1'b0;
    #1;
    check("arst_code",   32'(code_o),   32'd0);
    check("arst_thermo", 32'(thermo_o), 32'd0);
    check("arst_dir",    32'(dir_o),    32'd1);
    check("arst_tick",   32'(tick_o),   32'd0);
    cyc();
    cyc();
    rst_n = 1'b1; mode = 2'd3; en = 1'b1;
    cyc();
    cyc();
    check("post_rst_shadow_thermo", 32'(thermo_o), 32'd0);
    check("post_rst_shadow_code",   32'(code_o),   32'd0);
    check("post_rst_shadow_tick",   32'(tick_o),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
